// File: rtl/dds_wave_gen_pkg.sv
// dds_wave_gen_pkg: wave codes, sample-range helpers and reset constants for the DDS source
package dds_wave_gen_pkg;
  localparam logic [1:0] WAVE_SIN = 2'd0;
  localparam logic [1:0] WAVE_SQU = 2'd1;
  localparam logic [1:0] WAVE_SAW = 2'd2;
  localparam logic [1:0] WAVE_TRI = 2'd3;
  localparam logic [1:0] RST_WAVE = WAVE_SIN;
  localparam logic [1:0] RST_AMP  = 2'd0;
  function automatic int unsigned mid_val(int unsigned w);
    return 1 << (w - 1);
  endfunction
  function automatic int unsigned max_val(int unsigned w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/dds_wave_gen_if.sv
// dds_wave_gen_if: control, sine-ROM and DA-side signals of the DDS waveform source
interface dds_wave_gen_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
);
  logic               en;
  logic               sync_clr;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W-1:0] phase_ofs;
  logic [1:0]         wave_sel;
  logic [1:0]         amp_sh;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic [DATA_W-1:0]  da_data;
  logic               da_valid;
  logic               wrap_pulse;
  modport master (
    input  en, sync_clr, ftw, phase_ofs, wave_sel, amp_sh, rom_data,
    output rom_addr, da_data, da_valid, wrap_pulse
  );
  modport slave (
    output en, sync_clr, ftw, phase_ofs, wave_sel, amp_sh, rom_data,
    input  rom_addr, da_data, da_valid, wrap_pulse
  );
endinterface

// File: rtl/dds_wave_gen_phase_acc.sv
// dds_wave_gen_phase_acc: phase accumulator with wrap-gated shadow/active settings
module dds_wave_gen_phase_acc
  import dds_wave_gen_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               i_en,
  input  logic               i_sync_clr,
  input  logic [PHASE_W-1:0] i_ftw,
  input  logic [1:0]         i_wave_sel,
  input  logic [1:0]         i_amp_sh,
  output logic [PHASE_W-1:0] o_acc,
  output logic [1:0]         o_wave,
  output logic [1:0]         o_amp,
  output logic               o_wrap
);
  logic [PHASE_W-1:0] r_acc, r_ftw_act, r_ftw_sh;
  logic [1:0]         r_wave_act, r_wave_sh, r_amp_act, r_amp_sh;
  logic               r_wrap;
  logic [PHASE_W:0]   w_sum;
  logic               w_carry, w_load;
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw_act};
  assign w_carry = i_en & w_sum[PHASE_W];
  // a stalled accumulator (ftw 0) never wraps, so it takes new settings straight away
  assign w_load  = i_sync_clr | w_carry | (r_ftw_act == '0);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_acc      <= '0;
      r_ftw_act  <= '0;
      r_ftw_sh   <= '0;
      r_wave_act <= RST_WAVE;
      r_wave_sh  <= RST_WAVE;
      r_amp_act  <= RST_AMP;
      r_amp_sh   <= RST_AMP;
      r_wrap     <= 1'b0;
    end else begin
      r_ftw_sh  <= i_ftw;
      r_wave_sh <= i_wave_sel;
      r_amp_sh  <= i_amp_sh;
      r_acc     <= i_sync_clr ? '0 : i_en ? w_sum[PHASE_W-1:0] : r_acc;
      r_wrap    <= w_carry & ~i_sync_clr;
      if (w_load) begin
        r_ftw_act  <= r_ftw_sh;
        r_wave_act <= r_wave_sh;
        r_amp_act  <= r_amp_sh;
      end
    end
  assign o_acc  = r_acc;
  assign o_wave = r_wave_act;
  assign o_amp  = r_amp_act;
  assign o_wrap = r_wrap;
endmodule

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS waveform source feeding the DA converter from a phase accumulator
// and an external sine ROM; square, sawtooth and triangle are derived from the phase.
module dds_wave_gen
  import dds_wave_gen_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  dds_wave_gen_if.master bus
);
  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_val(DATA_W));
  localparam logic [DATA_W-1:0] MAX = DATA_W'(max_val(DATA_W));
  localparam logic [2:0] FLUSH_LAST = 3'(ROM_LAT + 1);
  typedef struct packed {
    logic [1:0]        wave;
    logic [1:0]        amp;
    logic [DATA_W-1:0] p;
  } tag_t;
  logic [PHASE_W-1:0]     w_acc;
  logic [1:0]             w_wave, w_amp;
  logic                   w_wrap;
  tag_t                   r_dly [ROM_LAT+1];
  tag_t                   w_tag;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_da, w_tri, w_s;
  logic signed [DATA_W:0] w_dev;
  logic [2:0]             r_cnt;
  logic                   r_valid;
  dds_wave_gen_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_en       (bus.en),
    .i_sync_clr (bus.sync_clr),
    .i_ftw      (bus.ftw),
    .i_wave_sel (bus.wave_sel),
    .i_amp_sh   (bus.amp_sh),
    .o_acc      (w_acc),
    .o_wave     (w_wave),
    .o_amp      (w_amp),
    .o_wrap     (w_wrap)
  );
  // the last delay-line entry lines up with rom_data for the same phase
  assign w_tag = r_dly[ROM_LAT];
  assign w_tri = w_tag.p[DATA_W-1] ? ~{w_tag.p[DATA_W-2:0], 1'b0} : {w_tag.p[DATA_W-2:0], 1'b0};
  assign w_s   = (w_tag.wave == WAVE_SQU) ? (w_tag.p[DATA_W-1] ? '0 : MAX) :
                 (w_tag.wave == WAVE_SAW) ? w_tag.p :
                 (w_tag.wave == WAVE_TRI) ? w_tri : bus.rom_data;
  assign w_dev = $signed({1'b0, w_s}) - $signed({1'b0, MID});
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_addr <= '0;
      for (int i = 0; i <= ROM_LAT; i++) r_dly[i] <= '{wave: RST_WAVE, amp: RST_AMP, p: '0};
      r_da    <= MID;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_addr   <= ADDR_W'((w_acc + bus.phase_ofs) >> (PHASE_W - ADDR_W));
      r_dly[0] <= '{wave: w_wave, amp: w_amp, p: DATA_W'((w_acc + bus.phase_ofs) >> (PHASE_W - DATA_W))};
      for (int i = 1; i <= ROM_LAT; i++) r_dly[i] <= r_dly[i-1];
      r_da <= MID + DATA_W'(w_dev >>> w_tag.amp);
      if (bus.sync_clr) begin
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else if (!r_valid) begin
        r_cnt   <= r_cnt + 3'd1;
        r_valid <= r_cnt == FLUSH_LAST;
      end
    end
  assign bus.rom_addr   = r_addr;
  assign bus.da_data    = r_da;
  assign bus.da_valid   = r_valid;
  assign bus.wrap_pulse = w_wrap;
endmodule
